// File: rtl/debug_unit_ctrl_pkg.sv
// Shared constants for the UART debug controller: default widths,
// command codes and FSM state types.
package debug_unit_ctrl_pkg;

   // Default widths
   localparam int unsigned DEF_UART_BITS        = 8;
   localparam int unsigned DEF_PC_BITS          = 11;
   localparam int unsigned DEF_INSTRUCTION_BITS = 32;
   localparam int unsigned DEF_PROC_BITS        = 32;
   localparam int unsigned DEF_DATA_ADDRS_BITS  = 10;
   localparam int unsigned DEF_SNAP_BITS        = 1024;
   localparam int unsigned DEF_CLK_COUNTER_BITS = 32;
   localparam int unsigned DEF_MEM_DUMP_WORDS   = 32;

   // Host command codes
   localparam logic [7:0] CMD_LOAD = 8'h01;
   localparam logic [7:0] CMD_RUN  = 8'h02;
   localparam logic [7:0] CMD_STEP = 8'h03;
   localparam logic [7:0] CMD_DUMP = 8'h04;
   localparam logic [7:0] CMD_BP   = 8'h05;

   // Controller states; ST_BP_BYTES is only reachable with breakpoint support
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LD_COUNT,
      ST_LD_BYTES,
      ST_LD_WRITE,
      ST_RUN,
      ST_STEP,
      ST_SNAP_TX,
      ST_CNT_TX,
      ST_MEM_REQ,
      ST_MEM_CAP,
      ST_MEM_TX,
      ST_BP_BYTES
   } dbg_state_e;

   // Serializer handshake states
   typedef enum logic [1:0] {
      SER_IDLE,
      SER_WAIT,
      SER_GUARD,
      SER_DONE
   } ser_state_e;

   // Number of bytes needed to carry 'bits' bits
   function automatic int unsigned bytes_for(input int unsigned bits,
                                             input int unsigned ub);
      return (bits + ub - 1) / ub;
   endfunction

endpackage

// File: rtl/debug_unit_ctrl_tx.sv
// debug_tx_serializer: takes one byte per load and runs the UART
// tx_start/tx_done handshake, reporting completion with a one-cycle byte_sent.
module debug_tx_serializer
   import debug_unit_ctrl_pkg::*;
#(
   parameter int unsigned UART_BITS = DEF_UART_BITS
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic [UART_BITS-1:0] data_i,
   input  logic                 tx_done_i,
   output logic                 tx_start_o,
   output logic [UART_BITS-1:0] tx_data_o,
   output logic                 busy_o,
   output logic                 byte_sent_o
);

   ser_state_e           state_q, state_d;
   logic [UART_BITS-1:0] byte_q, byte_d;
   logic [UART_BITS-1:0] tx_data_q, tx_data_d;
   logic                 start_q, start_d;

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= SER_IDLE;
         byte_q    <= '0;
         tx_data_q <= '0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         byte_q    <= byte_d;
         tx_data_q <= tx_data_d;
         start_q   <= start_d;
      end
   end

   // Handshake: start only when the transmitter reports idle, skip one
   // cycle after the pulse, then wait for idle again before completing
   always_comb begin
      state_d     = state_q;
      byte_d      = byte_q;
      tx_data_d   = tx_data_q;
      start_d     = 1'b0;
      byte_sent_o = 1'b0;
      case (state_q)
         SER_IDLE: begin
            if (load_i) begin
               byte_d  = data_i;
               state_d = SER_WAIT;
            end
         end
         SER_WAIT: begin
            if (tx_done_i) begin
               start_d   = 1'b1;
               tx_data_d = byte_q;
               state_d   = SER_GUARD;
            end
         end
         SER_GUARD: state_d = SER_DONE;
         SER_DONE: begin
            if (tx_done_i) begin
               byte_sent_o = 1'b1;
               state_d     = SER_IDLE;
            end
         end
         default: state_d = SER_IDLE;
      endcase
   end

   assign tx_start_o = start_q;
   assign tx_data_o  = tx_data_q;
   assign busy_o     = (state_q != SER_IDLE);

endmodule

// File: rtl/debug_unit_ctrl.sv
// debug_unit_ctrl: UART debug controller. Loads instruction memory, runs or
// single-steps the datapath, then streams snapshot, cycle counter and data
// memory as bytes. Optional breakpoint support: define DEBUG_BREAKPOINT_EN.
module debug_unit_ctrl
   import debug_unit_ctrl_pkg::*;
#(
   parameter int unsigned UART_BITS        = DEF_UART_BITS,
   parameter int unsigned PC_BITS          = DEF_PC_BITS,
   parameter int unsigned INSTRUCTION_BITS = DEF_INSTRUCTION_BITS,
   parameter int unsigned PROC_BITS        = DEF_PROC_BITS,
   parameter int unsigned DATA_ADDRS_BITS  = DEF_DATA_ADDRS_BITS,
   parameter int unsigned SNAP_BITS        = DEF_SNAP_BITS,
   parameter int unsigned CLK_COUNTER_BITS = DEF_CLK_COUNTER_BITS,
   parameter int unsigned MEM_DUMP_WORDS   = DEF_MEM_DUMP_WORDS
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [UART_BITS-1:0]        i_rx_data,
   input  logic                        i_rx_done,
   input  logic                        i_tx_done,
   input  logic                        i_halt,
   input  logic [PC_BITS-1:0]          i_pc,
   input  logic [SNAP_BITS-1:0]        i_snapshot,
   input  logic [PROC_BITS-1:0]        i_mem_data,
   output logic                        o_enable,
   output logic                        o_write_inst_mem,
   output logic [PC_BITS-1:0]          o_inst_mem_addr,
   output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
   output logic                        o_debug_read_data,
   output logic [DATA_ADDRS_BITS-1:0]  o_debug_read_address,
   output logic                        o_tx_start,
   output logic [UART_BITS-1:0]        o_tx_data
);

   localparam int unsigned IB = INSTRUCTION_BITS / UART_BITS;
   localparam int unsigned SB = SNAP_BITS / UART_BITS;
   localparam int unsigned CB = CLK_COUNTER_BITS / UART_BITS;
   localparam int unsigned PB = PROC_BITS / UART_BITS;

   dbg_state_e                  state_q, state_d;
   logic [INSTRUCTION_BITS-1:0] inst_q, inst_d;
   logic [PC_BITS-1:0]          k_q, k_d;
   logic [UART_BITS-1:0]        n_q, n_d;
   logic [15:0]                 bc_q, bc_d;
   logic [CLK_COUNTER_BITS-1:0] cnt_q, cnt_d;
   logic [CLK_COUNTER_BITS-1:0] cnt_sh_q, cnt_sh_d;
   logic [SNAP_BITS-1:0]        snap_q, snap_d;
   logic [PROC_BITS-1:0]        mem_sh_q, mem_sh_d;
   logic [DATA_ADDRS_BITS-1:0]  word_q, word_d;
   logic                        issued_q, issued_d;

   logic                        ser_load;
   logic [UART_BITS-1:0]        ser_byte;
   logic                        ser_busy;
   logic                        ser_sent;
   logic                        dump_entry;
   logic                        stop;

`ifdef DEBUG_BREAKPOINT_EN
   localparam int unsigned BPB = bytes_for(PC_BITS, UART_BITS);
   logic [BPB*UART_BITS-1:0] bp_shift_q, bp_shift_d;
   logic [PC_BITS-1:0]       bp_q, bp_d;
   logic                     bp_valid_q, bp_valid_d;

   assign stop = i_halt || (bp_valid_q && (i_pc == bp_q));

   // Breakpoint registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         bp_shift_q <= '0;
         bp_q       <= '0;
         bp_valid_q <= 1'b0;
      end else begin
         bp_shift_q <= bp_shift_d;
         bp_q       <= bp_d;
         bp_valid_q <= bp_valid_d;
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^i_pc;
   assign stop      = i_halt;
`endif

   // Main state and datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         inst_q   <= '0;
         k_q      <= '0;
         n_q      <= '0;
         bc_q     <= '0;
         cnt_q    <= '0;
         cnt_sh_q <= '0;
         snap_q   <= '0;
         mem_sh_q <= '0;
         word_q   <= '0;
         issued_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         inst_q   <= inst_d;
         k_q      <= k_d;
         n_q      <= n_d;
         bc_q     <= bc_d;
         cnt_q    <= cnt_d;
         cnt_sh_q <= cnt_sh_d;
         snap_q   <= snap_d;
         mem_sh_q <= mem_sh_d;
         word_q   <= word_d;
         issued_q <= issued_d;
      end
   end

   // Next-state logic: command decode, load assembly, run control, dump sequencing
   always_comb begin
      state_d    = state_q;
      inst_d     = inst_q;
      k_d        = k_q;
      n_d        = n_q;
      bc_d       = bc_q;
      cnt_d      = cnt_q;
      cnt_sh_d   = cnt_sh_q;
      snap_d     = snap_q;
      mem_sh_d   = mem_sh_q;
      word_d     = word_q;
      issued_d   = issued_q;
      ser_load   = 1'b0;
      ser_byte   = '0;
      dump_entry = 1'b0;
`ifdef DEBUG_BREAKPOINT_EN
      bp_shift_d = bp_shift_q;
      bp_d       = bp_q;
      bp_valid_d = bp_valid_q;
`endif

      if ((state_q == ST_RUN) || (state_q == ST_STEP)) begin
         cnt_d = cnt_q + CLK_COUNTER_BITS'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (i_rx_done) begin
               case (i_rx_data)
                  UART_BITS'(CMD_LOAD): begin
                     cnt_d   = '0;
                     state_d = ST_LD_COUNT;
                  end
                  UART_BITS'(CMD_RUN): begin
                     if (stop) dump_entry = 1'b1;
                     else      state_d    = ST_RUN;
                  end
                  UART_BITS'(CMD_STEP): state_d    = ST_STEP;
                  UART_BITS'(CMD_DUMP): dump_entry = 1'b1;
`ifdef DEBUG_BREAKPOINT_EN
                  UART_BITS'(CMD_BP): begin
                     bc_d    = '0;
                     state_d = ST_BP_BYTES;
                  end
`endif
                  default: ;
               endcase
            end
         end
         ST_LD_COUNT: begin
            if (i_rx_done) begin
               if (i_rx_data == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  n_d     = i_rx_data;
                  k_d     = '0;
                  bc_d    = '0;
                  state_d = ST_LD_BYTES;
               end
            end
         end
         ST_LD_BYTES: begin
            if (i_rx_done) begin
               // Bytes arrive LS first: shift right, insert at the top
               inst_d = (inst_q >> UART_BITS) |
                        (INSTRUCTION_BITS'(i_rx_data) << (INSTRUCTION_BITS - UART_BITS));
               if (bc_q == 16'(IB - 1)) begin
                  bc_d    = '0;
                  state_d = ST_LD_WRITE;
               end else begin
                  bc_d = bc_q + 16'd1;
               end
            end
         end
         ST_LD_WRITE: begin
            if (k_q == PC_BITS'(n_q) - PC_BITS'(1)) begin
               state_d = ST_IDLE;
            end else begin
               k_d     = k_q + PC_BITS'(1);
               state_d = ST_LD_BYTES;
            end
         end
         ST_RUN: begin
            if (stop) dump_entry = 1'b1;
         end
         ST_STEP: dump_entry = 1'b1;
         ST_SNAP_TX: begin
            if (!issued_q && !ser_busy) begin
               ser_load = 1'b1;
               ser_byte = snap_q[UART_BITS-1:0];
               issued_d = 1'b1;
            end
            if (ser_sent) begin
               issued_d = 1'b0;
               snap_d   = snap_q >> UART_BITS;
               if (bc_q == 16'(SB - 1)) begin
                  bc_d     = '0;
                  cnt_sh_d = cnt_q;
                  state_d  = ST_CNT_TX;
               end else begin
                  bc_d = bc_q + 16'd1;
               end
            end
         end
         ST_CNT_TX: begin
            if (!issued_q && !ser_busy) begin
               ser_load = 1'b1;
               ser_byte = cnt_sh_q[UART_BITS-1:0];
               issued_d = 1'b1;
            end
            if (ser_sent) begin
               issued_d = 1'b0;
               cnt_sh_d = cnt_sh_q >> UART_BITS;
               if (bc_q == 16'(CB - 1)) begin
                  bc_d    = '0;
                  word_d  = '0;
                  state_d = ST_MEM_REQ;
               end else begin
                  bc_d = bc_q + 16'd1;
               end
            end
         end
         ST_MEM_REQ: state_d = ST_MEM_CAP;
         ST_MEM_CAP: begin
            mem_sh_d = i_mem_data;
            bc_d     = '0;
            state_d  = ST_MEM_TX;
         end
         ST_MEM_TX: begin
            if (!issued_q && !ser_busy) begin
               ser_load = 1'b1;
               ser_byte = mem_sh_q[UART_BITS-1:0];
               issued_d = 1'b1;
            end
            if (ser_sent) begin
               issued_d = 1'b0;
               mem_sh_d = mem_sh_q >> UART_BITS;
               if (bc_q == 16'(PB - 1)) begin
                  bc_d = '0;
                  if (word_q == DATA_ADDRS_BITS'(MEM_DUMP_WORDS - 1)) begin
                     state_d = ST_IDLE;
                  end else begin
                     word_d  = word_q + DATA_ADDRS_BITS'(1);
                     state_d = ST_MEM_REQ;
                  end
               end else begin
                  bc_d = bc_q + 16'd1;
               end
            end
         end
`ifdef DEBUG_BREAKPOINT_EN
         ST_BP_BYTES: begin
            if (i_rx_done) begin
               bp_shift_d = (bp_shift_q >> UART_BITS) |
                            ((BPB*UART_BITS)'(i_rx_data) << ((BPB - 1) * UART_BITS));
               if (bc_q == 16'(BPB - 1)) begin
                  bp_d       = bp_shift_d[PC_BITS-1:0];
                  bp_valid_d = 1'b1;
                  bc_d       = '0;
                  state_d    = ST_IDLE;
               end else begin
                  bc_d = bc_q + 16'd1;
               end
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // Snapshot is registered once here so the whole dump shows one instant
      if (dump_entry) begin
         snap_d   = i_snapshot;
         bc_d     = '0;
         issued_d = 1'b0;
         state_d  = ST_SNAP_TX;
      end
   end

   debug_tx_serializer #(
      .UART_BITS(UART_BITS)
   ) u_tx (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ser_load),
      .data_i     (ser_byte),
      .tx_done_i  (i_tx_done),
      .tx_start_o (o_tx_start),
      .tx_data_o  (o_tx_data),
      .busy_o     (ser_busy),
      .byte_sent_o(ser_sent)
   );

   assign o_enable             = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign o_write_inst_mem     = (state_q == ST_LD_WRITE);
   assign o_inst_mem_addr      = k_q;
   assign o_inst_mem_data      = inst_q;
   assign o_debug_read_data    = (state_q == ST_MEM_REQ);
   assign o_debug_read_address = (state_q == ST_MEM_REQ) ? word_q : '0;

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Self-checking bench for debug_unit_ctrl: scoreboards for instruction
// writes and dumped bytes, a UART transmitter model and a 1-cycle memory.
module tb_debug_unit_ctrl;

   logic          clk;
   logic          rst;
   logic [7:0]    i_rx_data;
   logic          i_rx_done;
   logic          i_tx_done;
   logic          i_halt;
   logic [10:0]   i_pc;
   logic [1023:0] i_snapshot;
   logic [31:0]   i_mem_data;
   logic          o_enable;
   logic          o_write_inst_mem;
   logic [10:0]   o_inst_mem_addr;
   logic [31:0]   o_inst_mem_data;
   logic          o_debug_read_data;
   logic [9:0]    o_debug_read_address;
   logic          o_tx_start;
   logic [7:0]    o_tx_data;

   debug_unit_ctrl dut (
      .clk                 (clk),
      .rst                 (rst),
      .i_rx_data           (i_rx_data),
      .i_rx_done           (i_rx_done),
      .i_tx_done           (i_tx_done),
      .i_halt              (i_halt),
      .i_pc                (i_pc),
      .i_snapshot          (i_snapshot),
      .i_mem_data          (i_mem_data),
      .o_enable            (o_enable),
      .o_write_inst_mem    (o_write_inst_mem),
      .o_inst_mem_addr     (o_inst_mem_addr),
      .o_inst_mem_data     (o_inst_mem_data),
      .o_debug_read_data   (o_debug_read_data),
      .o_debug_read_address(o_debug_read_address),
      .o_tx_start          (o_tx_start),
      .o_tx_data           (o_tx_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [7:0] cmd;
      logic       clr;
      int         halt_after;
      int         exp_en;
      int         hold;
   } row_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  exp_q[$];
   wr_t         wr_q[$];
   int          en_cycles = 0;
   int          writes_seen = 0;
   int          tx_starts = 0;
   int          dump_bytes = 0;
   int          busy = 0;
   logic        tx_block = 1'b0;
   logic        mem_pend = 1'b0;
   logic [9:0]  mem_addr = '0;
   logic [9:0]  mem_next = '0;
   logic [31:0] cnt_model = '0;
   row_t        rows[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [9:0] a);
      return {6'h15, a, 6'h2A, a} ^ 32'h0F0F_0000;
   endfunction

   // Transmitter model, data memory model and output monitors
   initial begin
      i_tx_done  = 1'b1;
      i_mem_data = '0;
      forever begin
         @(negedge clk);
         if (o_enable) en_cycles++;
         if (o_write_inst_mem) begin
            wr_t w;
            writes_seen++;
            if (wr_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: actual addr %0h data %0h required none",
                        o_inst_mem_addr, o_inst_mem_data);
            end else begin
               w = wr_q.pop_front();
               check("write_addr", o_inst_mem_addr, w.addr);
               check("write_data", o_inst_mem_data, w.data);
            end
         end
         if (o_tx_start) begin
            tx_starts++;
            dump_bytes++;
            check("tx_start_needs_tx_done", i_tx_done, 1'b1);
            check("enable_during_dump", o_enable, 1'b0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_tx_byte: actual %0h required none", o_tx_data);
            end else begin
               check("tx_byte", o_tx_data, exp_q.pop_front());
            end
            busy = 3;
         end
         if (mem_pend) begin
            i_mem_data = mem_word(mem_addr);
            mem_pend   = 1'b0;
         end else begin
            i_mem_data = $urandom;
         end
         if (o_debug_read_data) begin
            check("read_addr", o_debug_read_address, mem_next);
            mem_next = mem_next + 10'd1;
            mem_pend = 1'b1;
            mem_addr = o_debug_read_address;
         end
         if (busy > 0) begin
            i_tx_done = 1'b0;
            busy--;
         end else begin
            i_tx_done = !tx_block;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      i_rx_data = b;
      i_rx_done = 1'b1;
      @(negedge clk);
      i_rx_done = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_dump(input logic [1023:0] snap, input logic [31:0] cnt);
      logic [31:0] w;
      for (int i = 0; i < 128; i++) exp_q.push_back(snap[i*8 +: 8]);
      for (int i = 0; i < 4; i++) exp_q.push_back(cnt[i*8 +: 8]);
      for (int a = 0; a < 32; a++) begin
         w = mem_word(10'(a));
         for (int b = 0; b < 4; b++) exp_q.push_back(w[b*8 +: 8]);
      end
      mem_next   = '0;
      dump_bytes = 0;
   endtask

   task automatic wait_dump(input string name);
      for (int t = 0; t < 6000; t++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
      idle(10);
   endtask

   task automatic do_cmd(input row_t r);
      int          en0;
      int          st0;
      int          ne;
      logic [31:0] exp_cnt;
      if (r.clr) begin
         send_byte(8'h01);
         send_byte(8'h00);
         cnt_model = '0;
         idle(4);
      end
      en0     = en_cycles;
      exp_cnt = cnt_model + 32'(r.exp_en);
      push_dump(i_snapshot, exp_cnt);
      if (r.hold > 0) tx_block = 1'b1;
      if (r.cmd == 8'h02 && r.halt_after == 0) i_halt = 1'b1;
      i_pc = '0;
      st0  = tx_starts;
      send_byte(r.cmd);
      if (r.cmd == 8'h02 && r.halt_after > 0) begin
         for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            #1;
            ne = en_cycles - en0;
            if (ne > 0) i_pc = 11'(ne - 1);
            if (ne == r.halt_after) i_halt = 1'b1;
            if (!o_enable && ne > 0) break;
         end
      end
      if (r.hold > 0) begin
         send_byte(8'h02);
         idle(r.hold);
         check("no_tx_start_while_tx_done_low", tx_starts - st0, 0);
         tx_block = 1'b0;
      end
      for (int t = 0; t < 200; t++) begin
         if (dump_bytes >= 1) break;
         @(negedge clk);
      end
      for (int i = 0; i < 32; i++) i_snapshot[i*32 +: 32] = $urandom;
      wait_dump("dump_complete");
      i_halt = 1'b0;
      check("enabled_cycles", en_cycles - en0, r.exp_en);
      check("dump_byte_count", dump_bytes, 260);
      cnt_model = exp_cnt;
   endtask

   initial begin
      int w0;
      int s0;
      int e0;

      rows[0] = '{8'h02, 1'b0, 7,  7, 0};
      rows[1] = '{8'h03, 1'b1, 0,  1, 0};
      rows[2] = '{8'h03, 1'b0, 0,  1, 0};
      rows[3] = '{8'h04, 1'b0, 0,  0, 50};
      rows[4] = '{8'h02, 1'b0, 0,  0, 0};
      rows[5] = '{8'h02, 1'b0, 12, 12, 0};

      rst       = 1'b0;
      i_rx_data = '0;
      i_rx_done = 1'b0;
      i_halt    = 1'b0;
      i_pc      = '0;
      for (int i = 0; i < 32; i++) i_snapshot[i*32 +: 32] = $urandom;
      idle(3);

      check("rst_enable",     o_enable, 1'b0);
      check("rst_write",      o_write_inst_mem, 1'b0);
      check("rst_inst_addr",  o_inst_mem_addr, 11'h0);
      check("rst_inst_data",  o_inst_mem_data, 32'h0);
      check("rst_read",       o_debug_read_data, 1'b0);
      check("rst_read_addr",  o_debug_read_address, 10'h0);
      check("rst_tx_start",   o_tx_start, 1'b0);
      check("rst_tx_data",    o_tx_data, 8'h00);
      rst = 1'b1;
      idle(2);

      // Reset in the middle of a load abandons it
      w0 = writes_seen;
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'hAA);
      send_byte(8'hBB);
      rst = 1'b0;
      idle(2);
      check("midload_rst_write", o_write_inst_mem, 1'b0);
      rst = 1'b1;
      idle(2);
      wr_q.push_back('{11'd0, 32'h0403_0201});
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      idle(5);
      check("load1_pending_writes", wr_q.size(), 0);
      check("load1_write_count", writes_seen - w0, 1);

      // Zero-count load, then RUN must be accepted
      w0 = writes_seen;
      send_byte(8'h01);
      send_byte(8'h00);
      idle(5);
      check("load0_write_count", writes_seen - w0, 0);
      cnt_model = '0;
      begin
         row_t r;
         r = '{8'h02, 1'b0, 3, 3, 0};
         do_cmd(r);
      end

      // Four-instruction load
      w0 = writes_seen;
      for (int k = 0; k < 4; k++)
         wr_q.push_back('{11'(k), {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}});
      send_byte(8'h01);
      send_byte(8'h04);
      for (int b = 0; b < 16; b++) send_byte(8'(b));
      idle(5);
      check("load4_pending_writes", wr_q.size(), 0);
      check("load4_write_count", writes_seen - w0, 4);
      cnt_model = '0;

      // Run / step / dump table
      for (int i = 0; i < 6; i++) do_cmd(rows[i]);

      // Unknown codes are ignored
      s0 = tx_starts;
      e0 = en_cycles;
      w0 = writes_seen;
      send_byte(8'h07);
      send_byte(8'hFF);
      idle(30);
      check("unknown_no_tx", tx_starts - s0, 0);
      check("unknown_no_enable", en_cycles - e0, 0);
      check("unknown_no_write", writes_seen - w0, 0);

      // Breakpoint at PC 5 (LS byte first), then RUN with halt at 10
      send_byte(8'h05);
      send_byte(8'h05);
      send_byte(8'h00);
      idle(3);
      begin
         row_t r;
`ifdef DEBUG_BREAKPOINT_EN
         r = '{8'h02, 1'b0, 10, 6, 0};
`else
         r = '{8'h02, 1'b0, 10, 10, 0};
`endif
         do_cmd(r);
      end

      idle(10);
      check("final_tx_queue", exp_q.size(), 0);
      check("final_write_queue", wr_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
